// File: rtl/alu_wb.sv
// alu_wb: two-entry write-back buffer between an ALU and the register file.
//
// Purpose
//   Holds up to two ALU results in FIFO order and presents the oldest one to
//   the register-file write port. Each entry records the result, the
//   destination register and a write enable. The write enable is cleared for
//   writes to r0 and for signed add/sub overflow traps. A trap also produces
//   a one-cycle exc pulse and bumps a saturating trap counter.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
//   ready are both 1. The producer holds valid and its data steady until that
//   edge. in_ready comes from the registered occupancy only, so out_ready has
//   no combinational path to in_ready. When the buffer is full, a pop frees a
//   slot that can be used from the next cycle on. out_valid likewise depends
//   only on registered state.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_r, in_aluc       ALU result and the opcode that produced it
//   in_zero/carry/negative/overflow   ALU flags for the result
//   in_rd               destination register index
//   out_valid/out_ready register-file handshake
//   out_r, out_rd       head entry result and destination
//   out_we              head write enable (0 whenever out_valid is 0)
//   flags               {zero, carry, negative, overflow} of the last accepted entry
//   exc                 one-cycle pulse after each accepted trap
//   exc_cnt             saturating count of accepted traps
module alu_wb #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_r,
  input  logic [3:0]  in_aluc,
  input  logic        in_zero,
  input  logic        in_carry,
  input  logic        in_negative,
  input  logic        in_overflow,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_r,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic [3:0]  flags,
  output logic        exc,
  output logic [7:0]  exc_cnt
);

  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0011;

  // Storage: two slots addressed by one-bit pointers that wrap 1 -> 0.
  logic [31:0] r_mem_q  [2];
  logic [4:0]  rd_mem_q [2];
  logic        we_mem_q [2];

  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic [3:0]  flags_q;
  logic        exc_q;
  logic [7:0]  exc_cnt_q;

  logic        accept;
  logic        pop;
  logic        trap;
  logic        wr_we;

  assign in_ready  = (count_q != 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Only signed add/sub overflow traps. Overflow reported for other opcodes
  // is informational and leaves the write enabled.
  assign trap  = ((in_aluc == ALUC_ADD) || (in_aluc == ALUC_SUB)) && in_overflow;
  assign wr_we = (in_rd != 5'd0) && !trap;

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem_q[i]  <= '0;
        rd_mem_q[i] <= '0;
        we_mem_q[i] <= 1'b0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      flags_q   <= 4'd0;
      exc_q     <= 1'b0;
      exc_cnt_q <= 8'd0;
    end else begin
      if (accept) begin
        r_mem_q[wr_ptr_q]  <= in_r;
        rd_mem_q[wr_ptr_q] <= in_rd;
        we_mem_q[wr_ptr_q] <= wr_we;
        wr_ptr_q           <= ~wr_ptr_q;
        flags_q            <= {in_zero, in_carry, in_negative, in_overflow};
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      exc_q   <= accept & trap;
      if (accept && trap && (exc_cnt_q != 8'hff)) begin
        exc_cnt_q <= exc_cnt_q + 8'd1;
      end
    end
  end

  assign out_r   = r_mem_q[rd_ptr_q];
  assign out_rd  = rd_mem_q[rd_ptr_q];
  // Gate with out_valid so a stale slot never presents a write.
  assign out_we  = out_valid & we_mem_q[rd_ptr_q];
  assign flags   = flags_q;
  assign exc     = exc_q;
  assign exc_cnt = exc_cnt_q;

endmodule

// File: tb/tb_alu_wb.sv
// Testbench for alu_wb: vector table, hand-written corner sequences and a
// randomized phase. Expected head entries go into exp_q when the bench drives
// an accepted request. A monitor pops and compares them when the DUT pops.
module tb_alu_wb;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_r;
  logic [3:0]  in_aluc;
  logic        in_zero, in_carry, in_negative, in_overflow;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [3:0]  flags;
  logic        exc;
  logic [7:0]  exc_cnt;

  alu_wb #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_r       (in_r),
    .in_aluc    (in_aluc),
    .in_zero    (in_zero),
    .in_carry   (in_carry),
    .in_negative(in_negative),
    .in_overflow(in_overflow),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .flags      (flags),
    .exc        (exc),
    .exc_cnt    (exc_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [37:0] exp_q[$];   // {r, rd, we}
  logic [7:0]  exp_cnt = 8'd0;
  logic [3:0]  exp_flags = 4'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_trap(input logic [3:0] a, input logic ov);
    return ((a == 4'b0010) || (a == 4'b0011)) && ov;
  endfunction

  function automatic logic model_we(input logic [3:0] a, input logic ov, input logic [4:0] rd);
    return (rd != 5'd0) && !model_trap(a, ov);
  endfunction

  // Monitor: the pop happens at the next rising edge when out_valid & out_ready
  // are high here, so the head is compared now while it is stable.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got rd %0d with empty expected queue", out_rd);
      end else begin
        check("pop_head", 64'({out_r, out_rd, out_we}), 64'(exp_q.pop_front()));
      end
    end
    if (!out_valid) check("out_we_idle", 64'(out_we), 64'(0));
  end

  // ---------------- driver ----------------
  // Called at posedge+1. Drives one cycle, predicts accept/trap from the
  // registered in_ready, then checks exc, exc_cnt and flags after the edge.
  task automatic do_cycle(input logic v, input logic [3:0] a, input logic [31:0] r,
                          input logic [3:0] fl, input logic [4:0] rd, input logic ordy);
    logic acc;
    logic trp;
    in_valid = v;
    in_aluc  = a;
    in_r     = r;
    {in_zero, in_carry, in_negative, in_overflow} = fl;
    in_rd     = rd;
    out_ready = ordy;
    acc = v && in_ready;
    trp = acc && model_trap(a, fl[0]);
    if (acc) begin
      exp_q.push_back({r, rd, model_we(a, fl[0], rd)});
      exp_flags = fl;
    end
    if (trp && exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
    @(posedge clk);
    #1;
    check("exc", 64'(exc), 64'(trp));
    check("exc_cnt", 64'(exc_cnt), 64'(exp_cnt));
    check("flags", 64'(flags), 64'(exp_flags));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  aluc;
    logic [31:0] r;
    logic [3:0]  fl;        // {zero, carry, negative, overflow}
    logic [4:0]  rd;
    logic        exp_we;
    logic        exp_exc;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int bound;

    vecs[0] = '{4'b0000, 32'h00000000, 4'b1100, 5'd3,  1'b1, 1'b0, 4'b1100};
    vecs[1] = '{4'b0010, 32'h80000000, 4'b0011, 5'd5,  1'b0, 1'b1, 4'b0011};
    vecs[2] = '{4'b0100, 32'haaaaaaaa, 4'b0000, 5'd0,  1'b0, 1'b0, 4'b0000};
    vecs[3] = '{4'b0001, 32'h12345678, 4'b0001, 5'd7,  1'b1, 1'b0, 4'b0001};
    vecs[4] = '{4'b0011, 32'h7fffffff, 4'b0101, 5'd9,  1'b0, 1'b1, 4'b0101};
    vecs[5] = '{4'b0011, 32'h00000001, 4'b0000, 5'd31, 1'b1, 1'b0, 4'b0000};
    vecs[6] = '{4'b0000, 32'hdeadbeef, 4'b0001, 5'd4,  1'b1, 1'b0, 4'b0001};
    vecs[7] = '{4'b0010, 32'hfffffffe, 4'b1011, 5'd0,  1'b0, 1'b1, 4'b1011};

    rst_n = 1'b0;
    in_valid = 1'b0; in_r = '0; in_aluc = '0; in_rd = '0;
    in_zero = 1'b0; in_carry = 1'b0; in_negative = 1'b0; in_overflow = 1'b0;
    out_ready = 1'b0;

    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_exc_cnt", 64'(exc_cnt), 64'(0));
    check("rst_flags", 64'(flags), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: single op through an empty buffer, latency one, then empty again.
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b1, vecs[i].aluc, vecs[i].r, vecs[i].fl, vecs[i].rd, 1'b1);
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
      check($sformatf("vec%0d_r", i), 64'(out_r), 64'(vecs[i].r));
      check($sformatf("vec%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
      check($sformatf("vec%0d_we", i), 64'(out_we), 64'(vecs[i].exp_we));
      check($sformatf("vec%0d_exc", i), 64'(exc), 64'(vecs[i].exp_exc));
      check($sformatf("vec%0d_flags", i), 64'(flags), 64'(vecs[i].exp_flags));
      do_cycle(1'b0, 4'd0, 32'd0, 4'd0, 5'd0, 1'b1);
      check($sformatf("vec%0d_empty", i), 64'(out_valid), 64'(0));
    end
    check("table_exc_cnt", 64'(exc_cnt), 64'(3));

    // Backpressure: rd 1,2 accepted, rd 3 stalls until a slot frees.
    do_cycle(1'b1, 4'b0000, 32'h11, 4'b0000, 5'd1, 1'b0);
    do_cycle(1'b1, 4'b0000, 32'h22, 4'b0000, 5'd2, 1'b0);
    check("bp_full_in_ready", 64'(in_ready), 64'(0));
    do_cycle(1'b1, 4'b0000, 32'h33, 4'b0000, 5'd3, 1'b0);
    check("bp_hold_in_ready", 64'(in_ready), 64'(0));
    check("bp_head_rd", 64'(out_rd), 64'(1));
    do_cycle(1'b1, 4'b0000, 32'h33, 4'b0000, 5'd3, 1'b1);  // pop rd1, no accept
    check("bp_ready_after_pop", 64'(in_ready), 64'(1));
    check("bp_head_rd2", 64'(out_rd), 64'(2));
    do_cycle(1'b1, 4'b0000, 32'h33, 4'b0000, 5'd3, 1'b1);  // pop rd2, accept rd3
    check("bp_head_rd3", 64'(out_rd), 64'(3));
    do_cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 5'd0, 1'b1);   // pop rd3
    check("bp_empty", 64'(out_valid), 64'(0));

    // Back-to-back traps give consecutive exc cycles.
    do_cycle(1'b1, 4'b0010, 32'h1, 4'b0001, 5'd6, 1'b1);
    check("b2b_exc0", 64'(exc), 64'(1));
    do_cycle(1'b1, 4'b0011, 32'h2, 4'b0001, 5'd6, 1'b1);
    check("b2b_exc1", 64'(exc), 64'(1));
    do_cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 5'd0, 1'b1);
    check("b2b_exc_end", 64'(exc), 64'(0));

    // Random traffic with concurrent push and pop.
    for (int i = 0; i < 80; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 4));
      do_cycle(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    bound = 0;
    while (out_valid && bound < 10) begin
      do_cycle(1'b0, 4'd0, 32'd0, 4'd0, 5'd0, 1'b1);
      bound++;
    end

    // Reset with two entries held discards them and clears the counter.
    do_cycle(1'b1, 4'b0000, 32'h88, 4'b0000, 5'd8, 1'b0);
    do_cycle(1'b1, 4'b0010, 32'h99, 4'b0001, 5'd9, 1'b0);
    check("pre_rst_full", 64'(in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt   = 8'd0;
    exp_flags = 4'd0;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_exc_cnt", 64'(exc_cnt), 64'(0));
    check("mid_rst_exc", 64'(exc), 64'(0));
    check("mid_rst_flags", 64'(flags), 64'(0));
    check("mid_rst_out_we", 64'(out_we), 64'(0));
    @(posedge clk);
    #1;
    check("rst_low_out_valid", 64'(out_valid), 64'(0));
    // First edge after release accepts.
    in_valid = 1'b1; in_aluc = 4'b0000; in_r = 32'h5; in_rd = 5'd9;
    {in_zero, in_carry, in_negative, in_overflow} = 4'b0000;
    out_ready = 1'b0;
    exp_q.push_back({32'h5, 5'd9, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post_rst_first_accept", 64'(out_valid), 64'(1));
    check("post_rst_exc", 64'(exc), 64'(0));
    check("post_rst_exc_cnt", 64'(exc_cnt), 64'(0));
    do_cycle(1'b0, 4'd0, 32'd0, 4'd0, 5'd0, 1'b1);
    check("post_rst_empty", 64'(out_valid), 64'(0));

    // Saturation: more than 256 traps leave the counter at 8'hff.
    for (int i = 0; i < 260; i++) begin
      do_cycle(1'b1, 4'b0011, i, 4'b0001, 5'd2, 1'b1);
    end
    do_cycle(1'b0, 4'd0, 32'd0, 4'd0, 5'd0, 1'b1);
    check("sat_exc_cnt", 64'(exc_cnt), 64'(8'hff));

    bound = 0;
    while (exp_q.size() != 0 && bound < 10) begin
      do_cycle(1'b0, 4'd0, 32'd0, 4'd0, 5'd0, 1'b1);
      bound++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_wb.md
ALU_WB -- requirements
Module: alu_wb

Interface
REQ-001 Parameter: DEPTH, 2, entries in the result buffer; only 2 supported.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  upstream ALU result present this cycle.
REQ-005 Port: in_ready  output  1  buffer can accept an entry this cycle.
REQ-006 Port: in_r  input  32  ALU result r.
REQ-007 Port: in_aluc  input  4  ALU opcode that produced in_r.
REQ-008 Port: in_zero, in_carry, in_negative, in_overflow  input  1 each  ALU flags.
REQ-009 Port: in_rd  input  5  destination register index.
REQ-010 Port: out_valid  output  1  head entry present.
REQ-011 Port: out_ready  input  1  register file consumes head this cycle.
REQ-012 Port: out_r  output  32  head result.
REQ-013 Port: out_rd  output  5  head destination.
REQ-014 Port: out_we  output  1  head write enable.
REQ-015 Port: flags  output  4  {zero, carry, negative, overflow} of last accepted entry.
REQ-016 Port: exc  output  1  one-cycle signed-overflow trap pulse.
REQ-017 Port: exc_cnt  output  8  saturating count of traps.

Function
REQ-018 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-019 in_ready SHALL be 1 exactly when occupancy < 2 (registered count, no combinational path from out_ready).
REQ-020 out_valid SHALL be 1 exactly when occupancy > 0; out_r/out_rd/out_we SHALL show the oldest entry.
REQ-021 Occupancy: accept only +1, pop only -1, both 0 change (FIFO order kept).
REQ-022 Full (occupancy 2) with out_ready=1: pop occurs, no accept that cycle; in_ready rises next cycle.
REQ-023 Empty: no bypass; entry accepted at edge N is visible on out_* in cycle after edge N (latency 1).
REQ-024 Stored we SHALL be 0 if in_rd == 0.
REQ-025 Stored we SHALL be 0 if in_aluc is 4'b0010 or 4'b0011 and in_overflow = 1 (signed add/sub trap); else 1 (subject to REQ-024).
REQ-026 On trap accept at edge N, exc SHALL be 1 for exactly the cycle after edge N; back-to-back traps give consecutive 1 cycles.
REQ-027 exc_cnt SHALL increment by 1 per trap accept, saturating at 8'hff.
REQ-028 flags SHALL load in_zero/in_carry/in_negative/in_overflow on every accept, hold otherwise.
REQ-029 Non-trap overflow (e.g. aluc 0000/0001 with in_overflow=1) SHALL neither suppress we nor pulse exc.
REQ-030 out_* contents when out_valid = 0 are don't-care except out_we, which SHALL be 0.
REQ-031 Read/write pointers 1 bit each, wrap 1 -> 0.

Reset
REQ-032 rst_n low SHALL immediately clear occupancy, pointers, flags, exc, exc_cnt, out_we to 0; in_ready = 1, out_valid = 0.
REQ-033 Reset mid-operation SHALL discard buffered entries; no pop or exc after release.
REQ-034 First accept possible at first rising edge with rst_n high.

Verification
REQ-035 Single op: aluc 0000, r 32'h00000000, zero=1, carry=1, rd 3, out_ready=1 -> next cycle out_valid=1, out_r 0, out_rd 3, out_we=1, flags 4'b1100; following cycle out_valid=0.
REQ-036 Trap: aluc 0010, r 32'h80000000, overflow=1, negative=1, rd 5 -> out_we=0, exc=1 one cycle, exc_cnt 1, flags 4'b0011.
REQ-037 Backpressure: out_ready=0, three valid requests rd 1,2,3 -> first two accepted, in_ready=0 on third; raise out_ready -> pops rd 1, rd 2, then rd 3 accepted and popped in order.
REQ-038 rd 0: aluc 0100, r 32'haaaaaaaa, rd 0 -> out_valid=1, out_we=0, exc=0.
REQ-039 Unsigned overflow: aluc 0001, overflow=1, rd 7 -> out_we=1, exc=0, exc_cnt unchanged.
REQ-040 Reset with 2 entries held -> out_valid=0, in_ready=1, exc_cnt 0 while rst_n low and after release; 256 traps -> exc_cnt stays 8'hff.
